// File: rtl/hack_run_controller.sv
// hack_run_controller: reset/clock-enable sequencer for the Hack CPU with run, halt, step, PC breakpoint and cycle counter
// Ports: i_clk clock, i_rst_n async active-low reset, i_cmd_valid/i_cmd/i_cmd_arg/o_cmd_ready command handshake
//        (0=RUN 1=STEP 2=HALT 3=RESET), i_pc CPU program counter, i_bp_en/i_bp_addr breakpoint,
//        o_cpu_rst/o_cpu_ce CPU control, o_halted, o_bp_hit sticky, o_state (0..4), o_cycle_count executed cycles
module hack_run_controller #(
  parameter int RST_CYCLES = 4,
  parameter int PC_W = 15,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [15:0]      i_cmd_arg,
  output logic             o_cmd_ready,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_bp_addr,
  output logic             o_cpu_rst,
  output logic             o_cpu_ce,
  output logic             o_halted,
  output logic             o_bp_hit,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);
  localparam int HW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_HALT = 2'd2;
  typedef enum logic [2:0] {S_HOLD, S_HALT, S_RUN, S_STEP, S_BREAK} state_t;
  state_t           r_state;
  logic [HW-1:0]    r_hold_cnt;
  logic [15:0]      r_step_rem;
  logic             r_skip;
  logic             r_cpu_rst;
  logic             r_bp_hit;
  logic [CNT_W-1:0] r_cycle_count;
  logic             w_stopped;
  logic             w_active;
  logic             w_bpm;
  logic             w_acc;
  logic             w_ovr;
  logic             w_hold_done;
  assign w_stopped   = (r_state == S_HALT) || (r_state == S_BREAK);
  assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_bpm       = i_bp_en && (i_pc == i_bp_addr) && !r_skip;
  assign w_acc       = i_cmd_valid && o_cmd_ready;
  // While running only HALT/RESET (cmd[1] set) take effect; RUN/STEP are accepted but ignored
  assign w_ovr       = w_acc && (w_stopped || i_cmd[1]);
  assign w_hold_done = r_hold_cnt == HW'(RST_CYCLES - 1);
  assign o_cmd_ready   = r_state != S_HOLD;
  assign o_cpu_ce      = w_active && !w_bpm;
  assign o_halted      = w_stopped;
  assign o_bp_hit      = r_bp_hit;
  assign o_cpu_rst     = r_cpu_rst;
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle_count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_HOLD;
      r_hold_cnt    <= '0;
      r_step_rem    <= '0;
      r_skip        <= 1'b0;
      r_cpu_rst     <= 1'b1;
      r_bp_hit      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_skip    <= 1'b0;
      r_cpu_rst <= 1'b0;
      if (o_cpu_ce) r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (o_cpu_ce && r_state == S_STEP) r_step_rem <= r_step_rem - 16'd1;
      if (r_state == S_HOLD) begin
        // cpu_rst drops on the same edge HALT is entered, giving exactly RST_CYCLES edges of reset
        r_cpu_rst  <= !w_hold_done;
        r_hold_cnt <= r_hold_cnt + HW'(1);
        if (w_hold_done) r_state <= S_HALT;
      end else if (w_ovr) begin
        unique case (i_cmd)
          C_RUN: begin
            r_state  <= S_RUN;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end
          C_STEP: begin
            r_state    <= S_STEP;
            r_step_rem <= i_cmd_arg == '0 ? 16'd1 : i_cmd_arg;
            r_skip     <= 1'b1;
            r_bp_hit   <= 1'b0;
          end
          C_HALT: begin
            r_state <= S_HALT;
            if (r_state == S_BREAK) r_bp_hit <= 1'b0;
          end
          default: begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_bp_hit      <= 1'b0;
            r_cpu_rst     <= 1'b1;
          end
        endcase
      end else if (w_active && w_bpm) begin
        r_state  <= S_BREAK;
        r_bp_hit <= 1'b1;
      end else if (r_state == S_STEP && o_cpu_ce && r_step_rem == 16'd1) begin
        r_state <= S_HALT;
      end
    end
  end
endmodule
